// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame path: FSM encoding, error codes
// and default framing constants.
package uart_pkg;

    // One-hot frame parser states.
    typedef enum logic [5:0] {
        ST_IDLE = 6'b000001,
        ST_HDR1 = 6'b000010,
        ST_ADDR = 6'b000100,
        ST_LEN  = 6'b001000,
        ST_PLD  = 6'b010000,
        ST_CHK  = 6'b100000
    } frm_state_t;

    // ERR_CODE values reported with FRM_ERR.
    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CHK  = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    // Default framing constants.
    localparam logic [7:0]  DEF_HDR0    = 8'h55;
    localparam logic [7:0]  DEF_HDR1    = 8'hAA;
    localparam logic [7:0]  DEF_MAX_LEN = 8'd64;
    localparam logic [19:0] DEF_TIMEOUT = 20'd1000000;

endpackage

// File: rtl/uart_timeout_cnt.sv
// Saturating up-counter with clear and enable. cnt_expire pulses in the
// cycle whose clock edge brings the count up to C_LIMIT; it ignores
// cnt_clr so the caller can decide precedence without a combinational loop.
module uart_timeout_cnt #(
    parameter int            W       = 20,
    parameter logic [W-1:0]  C_LIMIT = {W{1'b1}}
) (
    input  logic CLK_100M,
    input  logic IO_RESET,
    input  logic cnt_clr,
    input  logic cnt_en,
    output logic cnt_expire
);

    logic [W-1:0] cnt_reg;
    logic [W-1:0] cnt_next;

    // Next count: clear wins, otherwise count up and stick at the limit.
    always_comb begin
        cnt_next = cnt_reg;
        if (cnt_clr) begin
            cnt_next = '0;
        end else if (cnt_en && (cnt_reg != C_LIMIT)) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge CLK_100M or posedge IO_RESET) begin
        if (IO_RESET) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt_expire = cnt_en && (cnt_reg == (C_LIMIT - 1'b1));

endmodule

// File: rtl/uart_frame_parser.sv
// Byte-level frame decoder behind the UART receiver.
// Frame: HDR0 HDR1 ADDR LEN payload[LEN] CHK, CHK = XOR of ADDR, LEN, payload.
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter logic [7:0]  C_HDR0    = DEF_HDR0,
    parameter logic [7:0]  C_HDR1    = DEF_HDR1,
    parameter logic [7:0]  C_MAX_LEN = DEF_MAX_LEN,
    parameter logic [19:0] C_TIMEOUT = DEF_TIMEOUT
) (
    input  logic       CLK_100M,
    input  logic       IO_RESET,
    input  logic [7:0] UART_RX_DATA,
    input  logic       UART_RX_COMPLETE,
    output logic [7:0] FRM_ADDR,
    output logic [7:0] FRM_LEN,
    output logic [7:0] PLD_DATA,
    output logic [7:0] PLD_IDX,
    output logic       PLD_WE,
    output logic       FRM_DONE,
    output logic       FRM_ERR,
    output logic [1:0] ERR_CODE
);

    frm_state_t state_reg, state_next;
    logic [7:0] chk_reg, chk_next;
    logic [7:0] pld_cnt_reg, pld_cnt_next;
    logic [7:0] frm_addr_reg, frm_addr_next;
    logic [7:0] frm_len_reg, frm_len_next;
    logic [7:0] pld_data_reg, pld_data_next;
    logic [7:0] pld_idx_reg, pld_idx_next;
    logic       pld_we_reg, pld_we_next;
    logic       frm_done_reg, frm_done_next;
    logic       frm_err_reg, frm_err_next;
    logic [1:0] err_code_reg, err_code_next;

    logic rx_evt;
    logic in_idle;
    logic tmo_expire;
    logic tmo_fire;

    assign rx_evt  = UART_RX_COMPLETE;
    assign in_idle = (state_reg == ST_IDLE);
    // A byte arriving in the expiry cycle takes precedence over the timeout.
    assign tmo_fire = tmo_expire && !rx_evt;

    // Inter-byte silence counter; runs only while a frame is in progress.
    uart_timeout_cnt #(
        .W       (20),
        .C_LIMIT (C_TIMEOUT)
    ) u_timeout (
        .CLK_100M   (CLK_100M),
        .IO_RESET   (IO_RESET),
        .cnt_clr    (rx_evt || in_idle || tmo_expire),
        .cnt_en     (!in_idle),
        .cnt_expire (tmo_expire)
    );

    // Next-state and next-output decode; strobes default low, fields hold.
    always_comb begin
        state_next    = state_reg;
        chk_next      = chk_reg;
        pld_cnt_next  = pld_cnt_reg;
        frm_addr_next = frm_addr_reg;
        frm_len_next  = frm_len_reg;
        pld_data_next = pld_data_reg;
        pld_idx_next  = pld_idx_reg;
        pld_we_next   = 1'b0;
        frm_done_next = 1'b0;
        frm_err_next  = 1'b0;
        err_code_next = err_code_reg;

        if (rx_evt) begin
            case (state_reg)
                ST_IDLE: begin
                    if (UART_RX_DATA == C_HDR0) begin
                        state_next = ST_HDR1;
                    end
                end
                ST_HDR1: begin
                    // A repeated HDR0 keeps us aligned on the newest header.
                    if (UART_RX_DATA == C_HDR1) begin
                        state_next = ST_ADDR;
                    end else if (UART_RX_DATA != C_HDR0) begin
                        state_next = ST_IDLE;
                    end
                end
                ST_ADDR: begin
                    frm_addr_next = UART_RX_DATA;
                    chk_next      = UART_RX_DATA;
                    state_next    = ST_LEN;
                end
                ST_LEN: begin
                    frm_len_next = UART_RX_DATA;
                    chk_next     = chk_reg ^ UART_RX_DATA;
                    pld_cnt_next = 8'd0;
                    if (UART_RX_DATA > C_MAX_LEN) begin
                        frm_err_next  = 1'b1;
                        err_code_next = ERR_LEN;
                        state_next    = ST_IDLE;
                    end else if (UART_RX_DATA == 8'd0) begin
                        state_next = ST_CHK;
                    end else begin
                        state_next = ST_PLD;
                    end
                end
                ST_PLD: begin
                    pld_we_next   = 1'b1;
                    pld_data_next = UART_RX_DATA;
                    pld_idx_next  = pld_cnt_reg;
                    chk_next      = chk_reg ^ UART_RX_DATA;
                    pld_cnt_next  = pld_cnt_reg + 8'd1;
                    if (pld_cnt_reg == (frm_len_reg - 8'd1)) begin
                        state_next = ST_CHK;
                    end
                end
                ST_CHK: begin
                    if (UART_RX_DATA == chk_reg) begin
                        frm_done_next = 1'b1;
                    end else begin
                        frm_err_next  = 1'b1;
                        err_code_next = ERR_CHK;
                    end
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end else if (tmo_fire) begin
            frm_err_next  = 1'b1;
            err_code_next = ERR_TMO;
            state_next    = ST_IDLE;
        end
    end

    // State and registered outputs.
    always_ff @(posedge CLK_100M or posedge IO_RESET) begin
        if (IO_RESET) begin
            state_reg    <= ST_IDLE;
            chk_reg      <= 8'd0;
            pld_cnt_reg  <= 8'd0;
            frm_addr_reg <= 8'd0;
            frm_len_reg  <= 8'd0;
            pld_data_reg <= 8'd0;
            pld_idx_reg  <= 8'd0;
            pld_we_reg   <= 1'b0;
            frm_done_reg <= 1'b0;
            frm_err_reg  <= 1'b0;
            err_code_reg <= ERR_NONE;
        end else begin
            state_reg    <= state_next;
            chk_reg      <= chk_next;
            pld_cnt_reg  <= pld_cnt_next;
            frm_addr_reg <= frm_addr_next;
            frm_len_reg  <= frm_len_next;
            pld_data_reg <= pld_data_next;
            pld_idx_reg  <= pld_idx_next;
            pld_we_reg   <= pld_we_next;
            frm_done_reg <= frm_done_next;
            frm_err_reg  <= frm_err_next;
            err_code_reg <= err_code_next;
        end
    end

    assign FRM_ADDR = frm_addr_reg;
    assign FRM_LEN  = frm_len_reg;
    assign PLD_DATA = pld_data_reg;
    assign PLD_IDX  = pld_idx_reg;
    assign PLD_WE   = pld_we_reg;
    assign FRM_DONE = frm_done_reg;
    assign FRM_ERR  = frm_err_reg;
    assign ERR_CODE = err_code_reg;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: frame-level reference model compared every
// cycle, plus literal expectations for the directed scenarios.
module tb_uart_frame_parser;

    localparam int         TMO  = 100;
    localparam logic [7:0] MAXL = 8'd64;

    logic       CLK_100M = 1'b0;
    logic       IO_RESET = 1'b1;
    logic [7:0] UART_RX_DATA = 8'd0;
    logic       UART_RX_COMPLETE = 1'b0;
    logic [7:0] FRM_ADDR, FRM_LEN, PLD_DATA, PLD_IDX;
    logic       PLD_WE, FRM_DONE, FRM_ERR;
    logic [1:0] ERR_CODE;

    uart_frame_parser #(
        .C_HDR0    (8'h55),
        .C_HDR1    (8'hAA),
        .C_MAX_LEN (MAXL),
        .C_TIMEOUT (20'd100)
    ) dut (
        .CLK_100M         (CLK_100M),
        .IO_RESET         (IO_RESET),
        .UART_RX_DATA     (UART_RX_DATA),
        .UART_RX_COMPLETE (UART_RX_COMPLETE),
        .FRM_ADDR         (FRM_ADDR),
        .FRM_LEN          (FRM_LEN),
        .PLD_DATA         (PLD_DATA),
        .PLD_IDX          (PLD_IDX),
        .PLD_WE           (PLD_WE),
        .FRM_DONE         (FRM_DONE),
        .FRM_ERR          (FRM_ERR),
        .ERR_CODE         (ERR_CODE)
    );

    always #5 CLK_100M = ~CLK_100M;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    // Tracks position within the frame by the count of bytes collected
    // after the header, and derives the checksum from the stored bytes.
    bit          m_saw_hdr0 = 0;
    bit          m_in_frame = 0;
    byte unsigned m_frm[$];
    int          m_silence  = 0;
    logic [7:0]  e_addr = 0, e_len = 0, e_data = 0, e_idx = 0;
    logic        e_we = 0, e_done = 0, e_err = 0;
    logic [1:0]  e_code = 0;

    always @(posedge CLK_100M) begin
        logic [7:0] b;
        logic [7:0] sum;
        int n;
        e_we = 0; e_done = 0; e_err = 0;
        if (IO_RESET) begin
            e_addr = 0; e_len = 0; e_data = 0; e_idx = 0; e_code = 0;
            m_saw_hdr0 = 0; m_in_frame = 0; m_frm.delete(); m_silence = 0;
        end else if (UART_RX_COMPLETE) begin
            m_silence = 0;
            b = UART_RX_DATA;
            if (!m_in_frame) begin
                if (m_saw_hdr0) begin
                    if (b == 8'hAA) begin
                        m_in_frame = 1; m_saw_hdr0 = 0; m_frm.delete();
                    end else if (b != 8'h55) begin
                        m_saw_hdr0 = 0;
                    end
                end else if (b == 8'h55) begin
                    m_saw_hdr0 = 1;
                end
            end else begin
                m_frm.push_back(b);
                n = m_frm.size();
                if (n == 1) begin
                    e_addr = b;
                end else if (n == 2) begin
                    e_len = b;
                    if (b > MAXL) begin
                        e_err = 1; e_code = 2'd1; m_in_frame = 0;
                    end
                end else if (n <= int'(e_len) + 2) begin
                    e_we = 1; e_data = b; e_idx = 8'(n - 3);
                end else begin
                    sum = 0;
                    for (int i = 0; i < n - 1; i++) sum = sum ^ m_frm[i];
                    if (sum == b) e_done = 1;
                    else begin e_err = 1; e_code = 2'd2; end
                    m_in_frame = 0;
                end
            end
        end else if (m_saw_hdr0 || m_in_frame) begin
            m_silence++;
            if (m_silence == TMO) begin
                e_err = 1; e_code = 2'd3;
                m_saw_hdr0 = 0; m_in_frame = 0; m_silence = 0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge CLK_100M) begin
        if (IO_RESET) begin
            check("reset_outputs_zero",
                  64'({FRM_ADDR, FRM_LEN, PLD_DATA, PLD_IDX, PLD_WE, FRM_DONE, FRM_ERR, ERR_CODE}), 64'd0);
        end else begin
            check("frm_addr", 64'(FRM_ADDR), 64'(e_addr));
            check("frm_len",  64'(FRM_LEN),  64'(e_len));
            check("pld_we",   64'(PLD_WE),   64'(e_we));
            check("pld_data", 64'(PLD_DATA), 64'(e_data));
            check("pld_idx",  64'(PLD_IDX),  64'(e_idx));
            check("frm_done", 64'(FRM_DONE), 64'(e_done));
            check("frm_err",  64'(FRM_ERR),  64'(e_err));
            check("err_code", 64'(ERR_CODE), 64'(e_code));
        end
    end

    // ---------------- event capture for literal expectations ----------------
    int          cyc = 0;
    int          strobe_cyc = 0;
    int          err_cyc = 0;
    int          n_done = 0;
    int          n_err = 0;
    logic [1:0]  last_code = 0;
    byte unsigned wr_data[$];
    byte unsigned wr_idx[$];

    always @(posedge CLK_100M) cyc++;

    always @(negedge CLK_100M) begin
        if (!IO_RESET) begin
            if (PLD_WE) begin wr_data.push_back(PLD_DATA); wr_idx.push_back(PLD_IDX); end
            if (FRM_DONE) n_done++;
            if (FRM_ERR) begin n_err++; last_code = ERR_CODE; err_cyc = cyc; end
        end
    end

    task automatic clear_log();
        wr_data.delete(); wr_idx.delete(); n_done = 0; n_err = 0;
    endtask

    // Drivers: always entered and left 2 time units after a rising edge.
    task automatic send(input logic [7:0] b);
        UART_RX_DATA = b; UART_RX_COMPLETE = 1'b1;
        @(posedge CLK_100M); #2;
        UART_RX_COMPLETE = 1'b0;
        strobe_cyc = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge CLK_100M); #2; end
    endtask

    task automatic send_good(input logic [7:0] chk);
        send(8'h55); send(8'hAA); send(8'h10); send(8'h02);
        send(8'h11); send(8'h22); send(chk);
    endtask

    task automatic check_good_payload(input string tag);
        check({tag, "_wr_count"}, 64'(wr_data.size()), 64'd2);
        if (wr_data.size() == 2) begin
            check({tag, "_wr0_data"}, 64'(wr_data[0]), 64'h11);
            check({tag, "_wr0_idx"},  64'(wr_idx[0]),  64'h0);
            check({tag, "_wr1_data"}, 64'(wr_data[1]), 64'h22);
            check({tag, "_wr1_idx"},  64'(wr_idx[1]),  64'h1);
        end
    endtask

    initial begin
        @(posedge CLK_100M); #2;
        idle(2);
        IO_RESET = 1'b0;
        idle(2);
        check("after_reset_outputs",
              64'({FRM_ADDR, FRM_LEN, PLD_IDX, PLD_WE, FRM_DONE, FRM_ERR, ERR_CODE}), 64'd0);

        // Good frame, back-to-back bytes.
        clear_log();
        send_good(8'h21);
        check("good_done_next_cycle", 64'(FRM_DONE), 64'd1);
        idle(3);
        check_good_payload("good");
        check("good_done_count", 64'(n_done), 64'd1);
        check("good_err_count",  64'(n_err),  64'd0);
        check("good_addr", 64'(FRM_ADDR), 64'h10);
        check("good_len",  64'(FRM_LEN),  64'h02);

        // Bad checksum.
        clear_log();
        send_good(8'h20);
        check("badchk_err_next_cycle", 64'(FRM_ERR), 64'd1);
        idle(3);
        check_good_payload("badchk");
        check("badchk_done_count", 64'(n_done), 64'd0);
        check("badchk_code", 64'(last_code), 64'd2);

        // Length over the limit, then recovery.
        clear_log();
        send(8'h55); send(8'hAA); send(8'h01); send(8'h41);
        check("len_err_next_cycle", 64'(FRM_ERR), 64'd1);
        check("len_err_code", 64'(ERR_CODE), 64'd1);
        idle(3);
        check("len_no_writes", 64'(wr_data.size()), 64'd0);
        clear_log();
        send_good(8'h21);
        idle(3);
        check("len_recover_done", 64'(n_done), 64'd1);

        // Largest accepted length: 64 zero bytes, checksum 01^40.
        clear_log();
        send(8'h55); send(8'hAA); send(8'h01); send(8'h40);
        for (int i = 0; i < 64; i++) send(8'h00);
        send(8'h41);
        idle(3);
        check("max_len_wr_count", 64'(wr_idx.size()), 64'd64);
        if (wr_idx.size() == 64) check("max_len_last_idx", 64'(wr_idx[63]), 64'd63);
        check("max_len_done", 64'(n_done), 64'd1);

        // Header resync and zero-length frame, then a stray header.
        clear_log();
        send(8'h55); send(8'h55); send(8'hAA); send(8'h05); send(8'h00); send(8'h05);
        idle(3);
        check("zlen_done", 64'(n_done), 64'd1);
        check("zlen_len",  64'(FRM_LEN),  64'h00);
        check("zlen_addr", 64'(FRM_ADDR), 64'h05);
        clear_log();
        send(8'h55); send(8'h33);
        idle(TMO + 10);
        check("stray_hdr_silent", 64'(n_done + n_err), 64'd0);

        // Timeout after ADDR.
        clear_log();
        send(8'h55); send(8'hAA); send(8'h10);
        idle(TMO + 5);
        check("tmo_err_count", 64'(n_err), 64'd1);
        check("tmo_code", 64'(last_code), 64'd3);
        check("tmo_latency", 64'(err_cyc - strobe_cyc), 64'd100);

        // Byte landing on the expiry cycle wins.
        clear_log();
        send(8'h55); send(8'hAA); send(8'h10);
        idle(TMO - 1);
        send(8'h00); send(8'h10);
        idle(3);
        check("tmo_race_no_err", 64'(n_err), 64'd0);
        check("tmo_race_done", 64'(n_done), 64'd1);

        // Reset mid-payload, then replay.
        clear_log();
        send(8'h55); send(8'hAA); send(8'h10); send(8'h04); send(8'h01); send(8'h02);
        IO_RESET = 1'b1;
        idle(3);
        IO_RESET = 1'b0;
        idle(1);
        check("rst_idx_cleared",  64'(PLD_IDX),  64'd0);
        check("rst_addr_cleared", 64'(FRM_ADDR), 64'd0);
        check("rst_no_strobes", 64'(n_done + n_err), 64'd0);
        clear_log();
        send_good(8'h21);
        idle(3);
        check_good_payload("replay");
        check("replay_done", 64'(n_done), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
Byte-level frame decoder directly downstream of the UART receiver. It consumes the receiver's 8-bit data and one-cycle complete strobe, and recognises frames of the form HDR0, HDR1, ADDR, LEN, payload[LEN], CHK. Payload bytes go out as an indexed write stream for a downstream buffer. Each frame ends with a done pulse or an error pulse with a code.

Parameters:
C_HDR0, 8'h55, first header byte
C_HDR1, 8'hAA, second header byte
C_MAX_LEN, 8'd64, largest accepted LEN value (1..255)
C_TIMEOUT, 20'd1000000, inter-byte timeout in CLK_100M cycles (10 ms)

Ports:
CLK_100M  in  1  system clock, 100 MHz
IO_RESET  in  1  reset IO_RESET, asynchronous, active-high; clock CLK_100M
UART_RX_DATA  in  8  received byte, valid while UART_RX_COMPLETE=1
UART_RX_COMPLETE  in  1  one-cycle strobe, one received byte
FRM_ADDR  out  8  ADDR field of current/last frame
FRM_LEN  out  8  LEN field of current/last frame
PLD_DATA  out  8  payload byte
PLD_IDX  out  8  payload byte index, 0..LEN-1
PLD_WE  out  1  one-cycle payload write strobe
FRM_DONE  out  1  one-cycle strobe, frame accepted (checksum OK)
FRM_ERR  out  1  one-cycle strobe, frame aborted
ERR_CODE  out  2  01 length, 10 checksum, 11 timeout; held until the next FRM_ERR

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; checksum 0; timeout counter 0; payload counter 0.
- A byte event is UART_RX_COMPLETE=1. The FSM advances only on byte events and on timeout.
- All outputs are registered and appear 1 cycle after the byte event that causes them.
- FSM states: IDLE, HDR1, ADDR, LEN, PLD, CHK.
  - IDLE: byte==C_HDR0 -> HDR1. Any other byte is ignored.
  - HDR1: byte==C_HDR1 -> ADDR. byte==C_HDR0 -> stay in HDR1. Any other byte -> IDLE. None of these raise an error.
  - ADDR: latch FRM_ADDR; checksum := byte; -> LEN.
  - LEN: latch FRM_LEN; checksum ^= byte.
    - byte > C_MAX_LEN -> FRM_ERR, ERR_CODE=01, -> IDLE.
    - byte==0 -> CHK.
    - otherwise -> PLD, with payload counter := 0.
  - PLD: per byte: PLD_DATA=byte, PLD_IDX=counter, PLD_WE=1; checksum ^= byte; counter++. After byte number LEN (counter==LEN-1) -> CHK.
  - CHK: byte==checksum -> FRM_DONE=1. Otherwise FRM_ERR=1, ERR_CODE=10. Both cases -> IDLE.
- Checksum is the 8-bit XOR of ADDR, LEN and all payload bytes. Header bytes are excluded.
- Timeout:
  - A 20-bit counter clears on every byte event and in IDLE. Otherwise it increments, saturating at C_TIMEOUT.
  - When the count reaches C_TIMEOUT in any non-IDLE state: FRM_ERR=1, ERR_CODE=11, -> IDLE, counter cleared.
  - If a byte event and timeout expiry fall in the same cycle, the byte wins: it is processed normally and no timeout is raised.
- PLD_WE pulses only for accepted-length frames. Payload already written for an aborted frame is not retracted; the consumer discards it on FRM_ERR.
- FRM_DONE and FRM_ERR are never high together. Each is exactly 1 cycle wide.
- Back-to-back byte events on consecutive cycles are legal and must be handled without loss.
- Reset mid-frame: the partial frame is dropped; no strobes are issued.
- FRM_ADDR and FRM_LEN hold their values until the next ADDR or LEN byte respectively.

Decomposition:
- Shared package uart_pkg: FSM state encoding (one-hot, 6 bits), ERR_CODE constants (ERR_LEN=2'b01, ERR_CHK=2'b10, ERR_TMO=2'b11), default header constants.
- One natural sub-module: uart_timeout_cnt, a saturating counter with clear, enable and expiry pulse, reusable by the UART transmit path. All other logic stays flat.

Test Plan:
- Good frame 55 AA 10 02 11 22 21 -> PLD_WE at idx0=11 and idx1=22; FRM_ADDR=10, FRM_LEN=02; FRM_DONE 1 cycle after the 0x21 byte; FRM_ERR never asserted.
- Same frame with CHK=20 -> two PLD_WE pulses, then FRM_ERR=1 with ERR_CODE=10; no FRM_DONE.
- 55 AA 01 41 with C_MAX_LEN=64 -> FRM_ERR, ERR_CODE=01, 1 cycle after the LEN byte; no PLD_WE. A following good frame is accepted.
- Header resync: 55 55 AA 05 00 05 -> zero-length frame accepted, FRM_DONE=1, FRM_LEN=00. Then 55 33 -> returns to IDLE silently.
- Timeout: 55 AA 10 then silence; C_TIMEOUT overridden to 100 -> FRM_ERR with ERR_CODE=11 exactly 100 cycles after the last byte strobe. A byte arriving on cycle 100 instead suppresses the timeout.
- Assert IO_RESET mid-payload, then replay the good frame -> all outputs 0 during reset; the replayed frame gives FRM_DONE; no stale PLD_IDX.
